// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler: FSM state encoding and default sizing.
package counter_sched_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int CW_DEFAULT   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sched_tick_counter.sv
// Shared service counter: synchronous clear, count enable, and a compare against the latched terminal count.
module sched_tick_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          en,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] cnt,
  output logic          at_term
);

  always_ff @(posedge clk) begin
    if (clear)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CW'(1);
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin arbiter that lends one shared counter to a requester until it reaches that requester's terminal count.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int CW   = CW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [CW-1:0]     cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [CW-1:0]   len_q, len_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_idx;
  logic            win_valid;
  logic            cnt_clear, cnt_en, at_term;

  // Search starts just after the last granted index so every requester gets a turn.
  always_comb begin
    int cand;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    len_d     = len_q;
    ptr_d     = ptr_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d   = RUN;
          gnt_d     = NREQ'(1) << win_idx;
          len_d     = len[int'(win_idx)*CW +: CW];
          ptr_d     = win_idx;
          cnt_clear = 1'b1;
        end
      end
      RUN: begin
        // A dropped request aborts even if the count has just reached its end.
        if ((req & gnt_q) == '0) begin
          state_d   = IDLE;
          gnt_d     = '0;
          cnt_clear = 1'b1;
        end else if (at_term) begin
          state_d = DONE;
          gnt_d   = '0;
          done_d  = gnt_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      len_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
    end
  end

  sched_tick_counter #(.CW(CW)) u_counter (
    .clk     (clk),
    .clear   (cnt_clear | rst),
    .en      (cnt_en),
    .term    (len_q),
    .cnt     (cnt),
    .at_term (at_term)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed vector table plus hand-written corner sequences and a random-traffic invariant sweep for counter_scheduler.
module tb_counter_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  gnt, done, cnt;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [3:0] tracked_len = '0;
  logic [3:0] prev_gnt    = '0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  cnt;
    logic        chk_cnt;
  } vec_t;

  vec_t vecs[$];

  counter_scheduler #(.NREQ(4), .CW(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .cnt  (cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [15:0] ln);
    rst = r;
    req = rq;
    len = ln;
  endtask

  // Advance to the falling edge and check the invariants that must hold in every cycle.
  task automatic tick();
    @(negedge clk);
    if (rst) tracked_len = '0;
    else if (gnt != 0 && prev_gnt == 0)
      for (int i = 0; i < 4; i++) if (gnt[i]) tracked_len = len[i*4 +: 4];
    prev_gnt = gnt;
    tests++;
    if (!$onehot0(gnt) || !$onehot0(done) || (done != 0 && gnt != 0) ||
        (done != 0 && !busy) || (busy && cnt > tracked_len)) begin
      fails++;
      $display("[TB] FAIL invariant t=%0t got gnt=%b done=%b busy=%b cnt=%0d need onehot0, exclusive, cnt<=%0d",
               $time, gnt, done, busy, cnt, tracked_len);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [3:0] ed,
                             input logic eb, input logic [3:0] ec, input logic cc);
    tests++;
    if (gnt !== eg || done !== ed || busy !== eb || (cc && cnt !== ec)) begin
      fails++;
      $display("[TB] FAIL %s got gnt=%b done=%b busy=%b cnt=%0d expected gnt=%b done=%b busy=%b cnt=%0d%s",
               name, gnt, done, busy, cnt, eg, ed, eb, ec, cc ? "" : "(any)");
    end
  endtask

  function automatic void addVec(logic r, logic [3:0] rq, logic [15:0] ln, logic [3:0] g,
                                 logic [3:0] d, logic b, logic [3:0] c, logic cc);
    vec_t v;
    v.rst = r; v.req = rq; v.len = ln; v.gnt = g; v.done = d; v.busy = b; v.cnt = c; v.chk_cnt = cc;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [3:0] order [4];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000;

    // Single request, len0=3.
    addVec(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0, 1);
    addVec(0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 0, 1);
    addVec(0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 1, 1);
    addVec(0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 2, 1);
    addVec(0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 3, 1);
    addVec(0, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 1, 3, 1);
    addVec(0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 0, 0, 0);
    // Full contention, every len=1: four cycles per service, rotating from requester 0.
    addVec(1, 4'b1111, 16'h1111, 4'b0000, 4'b0000, 0, 0, 1);
    for (int s = 0; s < 5; s++) begin
      addVec(0, 4'b1111, 16'h1111, order[s % 4], 4'b0000, 1, 0, 1);
      addVec(0, 4'b1111, 16'h1111, order[s % 4], 4'b0000, 1, 1, 1);
      if (s < 4) begin
        addVec(0, 4'b1111, 16'h1111, 4'b0000, order[s], 1, 1, 1);
        addVec(0, 4'b1111, 16'h1111, 4'b0000, 4'b0000, 0, 0, 0);
      end
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].len);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].cnt, vecs[i].chk_cnt);
    end

    // len=0: a single RUN cycle at cnt=0.
    applyStimulus(1, 4'b0000, 16'h0000); tick();
    applyStimulus(0, 4'b0001, 16'h0000); tick();
    checkOutput("len0_run", 4'b0001, 4'b0000, 1, 0, 1);
    tick();
    checkOutput("len0_done", 4'b0000, 4'b0001, 1, 0, 1);
    applyStimulus(0, 4'b0000, 16'h0000); tick();
    checkOutput("len0_idle", 4'b0000, 4'b0000, 0, 0, 0);

    // len=15 counts to all-ones without wrapping; a len change after the grant is ignored.
    applyStimulus(1, 4'b0000, 16'h0000); tick();
    applyStimulus(0, 4'b0001, 16'h000F); tick();
    applyStimulus(0, 4'b0001, 16'h0000);
    for (int c = 0; c < 16; c++) begin
      checkOutput($sformatf("len15_run%0d", c), 4'b0001, 4'b0000, 1, 4'(c), 1);
      tick();
    end
    checkOutput("len15_done", 4'b0000, 4'b0001, 1, 4'd15, 1);
    applyStimulus(0, 4'b0000, 16'h0000); tick();

    // Abort at cnt=2 hands over to the pending requester 1.
    applyStimulus(1, 4'b0000, 16'h0000); tick();
    applyStimulus(0, 4'b0011, 16'h0025); tick(); tick(); tick();
    checkOutput("abort_cnt2", 4'b0001, 4'b0000, 1, 2, 1);
    applyStimulus(0, 4'b0010, 16'h0025); tick();
    checkOutput("abort_idle", 4'b0000, 4'b0000, 0, 0, 1);
    tick();
    checkOutput("abort_next", 4'b0010, 4'b0000, 1, 0, 1);
    applyStimulus(0, 4'b0000, 16'h0025); tick(); tick();

    // Abort wins over completion in the same cycle.
    applyStimulus(1, 4'b0000, 16'h0000); tick();
    applyStimulus(0, 4'b0001, 16'h0001); tick(); tick();
    checkOutput("prio_cnt1", 4'b0001, 4'b0000, 1, 1, 1);
    applyStimulus(0, 4'b0000, 16'h0001); tick();
    checkOutput("prio_abort", 4'b0000, 4'b0000, 0, 0, 1);

    // Reset mid-RUN, then the lowest pending index wins.
    applyStimulus(1, 4'b0000, 16'h0000); tick();
    applyStimulus(0, 4'b1000, 16'h5000); tick();
    checkOutput("rstrun_gnt", 4'b1000, 4'b0000, 1, 0, 1);
    tick(); tick(); tick();
    checkOutput("rstrun_cnt3", 4'b1000, 4'b0000, 1, 3, 1);
    applyStimulus(1, 4'b1100, 16'h5000); tick();
    checkOutput("rstrun_reset", 4'b0000, 4'b0000, 0, 0, 1);
    applyStimulus(0, 4'b1100, 16'h5000); tick();
    checkOutput("rstrun_first", 4'b0100, 4'b0000, 1, 0, 1);

    // Random traffic; only the per-cycle invariants are checked.
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  rq;
      logic [15:0] ln;
      rq = req;
      ln = len;
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ln = 16'($urandom);
      applyStimulus($urandom_range(0, 31) == 0, rq, ln);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
